// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: FSM state type, select-width helper and parameter range check
// shared by the fifo_arbiter_rr slice.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int sel_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic bit params_ok(input int num_ch, input int rd_lat, input int max_burst);
        return (num_ch >= 2) && (num_ch <= 16) &&
               (rd_lat >= 0) && (rd_lat <= 3) &&
               (max_burst >= 1) && (max_burst <= 15);
    endfunction

endpackage

// File: rtl/fifo_arbiter_rr_pick.sv
// arb_rr_pick: combinational winner search over req & ~excl, starting at base
// and wrapping; with base tied to 0 it is a plain lowest-index priority pick.
module arb_rr_pick #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  base,
    input  logic [NUM_CH-1:0] excl,
    output logic [SEL_W-1:0]  grant,
    output logic              valid
);

    logic [NUM_CH-1:0] cand;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cand
            assign cand[gi] = req[gi] & ~excl[gi];
        end
    endgenerate

    // base can exceed NUM_CH-1 only for non-power-of-two NUM_CH; two folds cover it.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(base) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!valid && cand[idx]) begin
                valid = 1'b1;
                grant = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_arbiter_rr.sv
// fifo_arbiter_rr: one-hot pop arbiter for NUM_CH input/output FIFO pairs sharing a mux.
// Define FIFO_ARB_RR_EN for round-robin winner search; otherwise lowest eligible index wins.
module fifo_arbiter_rr
    import fifo_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        empty_in,
    input  logic [NUM_CH-1:0]        almost_empty_in,
    input  logic [NUM_CH-1:0]        almost_full_out,
    output logic [NUM_CH-1:0]        pop,
    output logic [sel_w(NUM_CH)-1:0] select,
    output logic [NUM_CH-1:0]        push,
    output logic [sel_w(NUM_CH)-1:0] push_select,
    output logic                     busy
);

    localparam int SEL_W   = sel_w(NUM_CH);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    generate
        if (!params_ok(NUM_CH, RD_LAT, MAX_BURST)) begin : g_param_err
            $error("fifo_arbiter_rr: NUM_CH/RD_LAT/MAX_BURST out of range");
        end
    endgenerate

    arb_state_e          state_reg, state_next;
    logic [SEL_W-1:0]    cur_reg, cur_next;
    logic [BURST_W-1:0]  burst_reg, burst_next;
    logic [NUM_CH-1:0]   pop_reg, pop_next;
    logic [NUM_CH-1:0]   elig, cur_oh, excl;
    logic [SEL_W-1:0]    base, pick_idx;
    logic                pick_valid;
    logic                line_busy;

    // A channel whose last entry is being popped right now must not be popped again.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_elig
            assign elig[gi] = !empty_in[gi] && !almost_full_out[gi] &&
                              !(pop_reg[gi] && almost_empty_in[gi]);
        end
    endgenerate

    always_comb begin
        cur_oh          = '0;
        cur_oh[cur_reg] = 1'b1;
    end

    // Only consulted when cur cannot continue; keep cur unless it is the sole candidate.
    assign excl = ((state_reg == GRANT) && ((elig & ~cur_oh) != '0)) ? cur_oh : '0;

`ifdef FIFO_ARB_RR_EN
    logic [SEL_W-1:0] last_reg, last_next;
    assign base = (last_reg == SEL_W'(NUM_CH - 1)) ? '0 : last_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) last_reg <= SEL_W'(NUM_CH - 1);
        else        last_reg <= last_next;
    end
`else
    assign base = '0;
`endif

    arb_rr_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_pick (
        .req   (elig),
        .base  (base),
        .excl  (excl),
        .grant (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_next = state_reg;
        cur_next   = cur_reg;
        burst_next = burst_reg;
`ifdef FIFO_ARB_RR_EN
        last_next  = last_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next = GRANT;
                    cur_next   = pick_idx;
                    burst_next = BURST_W'(1);
                end
            end
            GRANT: begin
                if (elig[cur_reg] && (burst_reg < BURST_W'(MAX_BURST))) begin
                    burst_next = burst_reg + 1'b1;
                end else begin
`ifdef FIFO_ARB_RR_EN
                    last_next = cur_reg;
`endif
                    if (pick_valid) begin
                        cur_next   = pick_idx;
                        burst_next = BURST_W'(1);
                    end else begin
                        state_next = IDLE;
                        burst_next = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop_next = '0;
        if (state_next == GRANT) pop_next[cur_next] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            cur_reg   <= '0;
            burst_reg <= '0;
            pop_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cur_reg   <= cur_next;
            burst_reg <= burst_next;
            pop_reg   <= pop_next;
        end
    end

    assign pop    = pop_reg;
    assign select = cur_reg;

    // Push path: {pop, select} delayed by the input FIFO read latency, lane i -> output i.
    generate
        if (RD_LAT == 0) begin : g_no_delay
            assign push        = pop_reg;
            assign push_select = cur_reg;
            assign line_busy   = 1'b0;
        end else begin : g_delay
            logic [NUM_CH-1:0] dl_pop_reg [RD_LAT];
            logic [SEL_W-1:0]  dl_sel_reg [RD_LAT];

            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int k = 0; k < RD_LAT; k++) begin
                        dl_pop_reg[k] <= '0;
                        dl_sel_reg[k] <= '0;
                    end
                end else begin
                    dl_pop_reg[0] <= pop_reg;
                    dl_sel_reg[0] <= cur_reg;
                    for (int k = 1; k < RD_LAT; k++) begin
                        dl_pop_reg[k] <= dl_pop_reg[k-1];
                        dl_sel_reg[k] <= dl_sel_reg[k-1];
                    end
                end
            end

            always_comb begin
                line_busy = 1'b0;
                for (int k = 0; k < RD_LAT; k++) line_busy = line_busy | (|dl_pop_reg[k]);
            end

            assign push        = dl_pop_reg[RD_LAT-1];
            assign push_select = dl_sel_reg[RD_LAT-1];
        end
    endgenerate

    assign busy = (|pop_reg) | line_busy;

endmodule

// File: tb/tb_fifo_arbiter_rr.sv
// tb_fifo_arbiter_rr: directed vectors for fifo_arbiter_rr (NUM_CH=4, RD_LAT=1, MAX_BURST=4);
// expected sequences follow FIFO_ARB_RR_EN when it is defined.
module tb_fifo_arbiter_rr;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] empty_in, almost_empty_in, almost_full_out;
    logic [3:0] pop, push;
    logic [1:0] select, push_select;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    fifo_arbiter_rr #(
        .NUM_CH    (4),
        .RD_LAT    (1),
        .MAX_BURST (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .empty_in        (empty_in),
        .almost_empty_in (almost_empty_in),
        .almost_full_out (almost_full_out),
        .pop             (pop),
        .select          (select),
        .push            (push),
        .push_select     (push_select),
        .busy            (busy)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t rst_n=%b empty=%b pop=%b sel=%0d push=%b psel=%0d busy=%b",
                 $time, reset, empty_in, pop, select, push, push_select, busy);
    endtask

    // Steps one cycle per entry of exp_q, checking pop/select and the RD_LAT=1 push echo.
    task automatic run_seq(input string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            tick();
            check_vec($sformatf("%s_pop%0d", name, i), 32'(pop), 32'(1) << exp_q[i]);
            check_vec($sformatf("%s_sel%0d", name, i), 32'(select), 32'(exp_q[i]));
            if (i == 0) begin
                check_vec($sformatf("%s_push%0d", name, i), 32'(push), 32'(0));
            end else begin
                check_vec($sformatf("%s_push%0d", name, i), 32'(push), 32'(1) << exp_q[i-1]);
                check_vec($sformatf("%s_psel%0d", name, i), 32'(push_select), 32'(exp_q[i-1]));
            end
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b0;
        empty_in        = 4'hF;
        almost_empty_in = 4'hF;
        almost_full_out = 4'h0;

        // Reset state
        tick();
        tick();
        check_vec("rst_pop",  32'(pop), 32'(0));
        check_vec("rst_push", 32'(push), 32'(0));
        check_vec("rst_sel",  32'(select), 32'(0));
        check_vec("rst_psel", 32'(push_select), 32'(0));
        check_vec("rst_busy", 32'(busy), 32'(0));
        reset = 1'b1;
        tick();
        check_vec("idle_pop", 32'(pop), 32'(0));

        // Single grant on channel 2, push one cycle later
        empty_in        = 4'b1011;
        almost_empty_in = 4'b1011;
        tick();
        check_vec("t1_pop",  32'(pop), 32'h4);
        check_vec("t1_sel",  32'(select), 32'(2));
        check_vec("t1_push", 32'(push), 32'(0));
        check_vec("t1_busy", 32'(busy), 32'(1));
        empty_in        = 4'hF;
        almost_empty_in = 4'hF;
        tick();
        check_vec("t1_pop_off",   32'(pop), 32'(0));
        check_vec("t1_sel_hold",  32'(select), 32'(2));
        check_vec("t1_push_on",   32'(push), 32'h4);
        check_vec("t1_psel",      32'(push_select), 32'(2));
        check_vec("t1_busy_push", 32'(busy), 32'(1));
        tick();
        check_vec("t1_push_off", 32'(push), 32'(0));
        check_vec("t1_busy_off", 32'(busy), 32'(0));

        // Burst limit between two deep channels
        empty_in        = 4'b1100;
        almost_empty_in = 4'b1100;
        exp_q = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        run_seq("burst");
        empty_in        = 4'hF;
        almost_empty_in = 4'hF;
        tick();
        check_vec("burst_end_pop",  32'(pop), 32'(0));
        check_vec("burst_end_push", 32'(push), 32'h1);
        tick();

        // Single-entry channel 3: empty flag still low while its pop is in progress
        empty_in        = 4'b0111;
        almost_empty_in = 4'hF;
        tick();
        check_vec("single_pop", 32'(pop), 32'h8);
        tick();
        check_vec("single_no_repop", 32'(pop), 32'(0));
        check_vec("single_push",     32'(push), 32'h8);
        empty_in = 4'hF;
        tick();
        check_vec("single_idle_pop",  32'(pop), 32'(0));
        check_vec("single_idle_busy", 32'(busy), 32'(0));

        // Backpressure on channel 1 mid-burst diverts to channel 2
        empty_in        = 4'b1001;
        almost_empty_in = 4'b1001;
        tick();
        check_vec("af_pop0", 32'(pop), 32'h2);
        tick();
        check_vec("af_pop1", 32'(pop), 32'h2);
        almost_full_out = 4'b0010;
        tick();
        check_vec("af_switch",      32'(pop), 32'h4);
        check_vec("af_switch_push", 32'(push), 32'h2);
        almost_full_out = 4'b0000;
        empty_in        = 4'b1101;
        almost_empty_in = 4'b1101;
        tick();
        check_vec("af_resume",      32'(pop), 32'h2);
        check_vec("af_resume_push", 32'(push), 32'h4);
        check_vec("af_resume_psel", 32'(push_select), 32'(2));
        empty_in        = 4'hF;
        almost_empty_in = 4'hF;
        tick();
        tick();

        // All four channels contending
        empty_in        = 4'h0;
        almost_empty_in = 4'h0;
`ifdef FIFO_ARB_RR_EN
        exp_q = '{2, 2, 2, 2, 3, 3, 3, 3, 0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_q = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
`endif
        run_seq("contend");
        check_vec("contend_busy", 32'(busy), 32'(1));

        // Reset mid-burst with a push pending
        reset = 1'b0;
        tick();
        check_vec("mid_rst_pop",  32'(pop), 32'(0));
        check_vec("mid_rst_push", 32'(push), 32'(0));
        check_vec("mid_rst_sel",  32'(select), 32'(0));
        check_vec("mid_rst_psel", 32'(push_select), 32'(0));
        check_vec("mid_rst_busy", 32'(busy), 32'(0));
        reset           = 1'b1;
        empty_in        = 4'hF;
        almost_empty_in = 4'hF;
        tick();
        check_vec("post_rst_pop", 32'(pop), 32'(0));
        empty_in        = 4'b1110;
        almost_empty_in = 4'b1110;
        tick();
        check_vec("post_rst_grant", 32'(pop), 32'h1);
        check_vec("post_rst_sel",   32'(select), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
